pwm_3l_modulator: RTL

- Carrier-based 3-level PWM modulator. It sits directly upstream of decoder_3lxnpc and produces the 2-bit v_lev level command that the decoder translates into S_out gate signals.
- Uses one symmetric triangular carrier and compares it against the magnitude of a signed duty reference; the reference sign selects the P or N level.
- Reference and period are double-buffered and loaded at carrier peak and valley, so a PWM pulse is never cut mid-period.

---
 rtl/pwm_3l_modulator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_3l_modulator.sv
// ---------------------------------------------------------------------------
// pwm_3l_modulator
//
// Carrier-based 3-level PWM modulator feeding decoder_3lxnpc. A symmetric
// triangular carrier is compared against |ref|; the reference sign selects
// the positive (01) or negative (10) level. The reference is double-buffered
// and reloaded at every carrier peak and valley. The period is reloaded at
// valleys only. A direct 01<->10 change is always separated by MIN_ZERO
// cycles of 00.
//
// Optional feature macro: MIN_PULSE_EN
//   defined   : magnitudes below MIN_PULSE are dropped to 0; magnitudes
//               within MIN_PULSE of the period are raised to full on.
//   undefined : the magnitude is used as is and MIN_PULSE has no effect.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   en          modulator enable
//   period      carrier peak value (switching period = 2*period cycles)
//   ref_in      signed duty reference, CNT_WIDTH+1 bits two's complement
//   ref_valid   one-cycle strobe capturing ref_in into the pending register
//   v_lev       level command: 00 zero, 01 positive, 10 negative
//   carrier     current carrier count
//   sync_valley one-cycle pulse while carrier = 0
//   sync_peak   one-cycle pulse while carrier = active period
// ---------------------------------------------------------------------------
module pwm_3l_modulator #(
    parameter int CNT_WIDTH = 16,
    parameter int MIN_ZERO  = 1,
    parameter int MIN_PULSE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH:0]   ref_in,
    input  logic                 ref_valid,
    output logic [1:0]           v_lev,
    output logic [CNT_WIDTH-1:0] carrier,
    output logic                 sync_valley,
    output logic                 sync_peak
);

`ifdef MIN_PULSE_EN
    localparam bit PULSE_GUARD = 1'b1;
`else
    localparam bit PULSE_GUARD = 1'b0;
`endif

    localparam logic [CNT_WIDTH:0] MIN_PULSE_C = (CNT_WIDTH+1)'(MIN_PULSE);
    localparam logic [7:0]         HOLD_INIT   = 8'(MIN_ZERO - 1);

    localparam logic [1:0] LEV_ZERO = 2'b00;
    localparam logic [1:0] LEV_POS  = 2'b01;
    localparam logic [1:0] LEV_NEG  = 2'b10;

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 dir_up_reg, dir_up_next;
    logic                 run_reg;
    logic [CNT_WIDTH:0]   ref_pend_reg, ref_pend_next;
    logic [CNT_WIDTH:0]   ref_act_reg;
    logic [CNT_WIDTH-1:0] period_act_reg;
    logic                 sync_valley_reg, sync_valley_next;
    logic                 sync_peak_reg, sync_peak_next;
    logic [1:0]           v_lev_reg, v_lev_next;
    logic [7:0]           hold_reg, hold_next;

    logic                 step_up;
    logic                 load_ref, load_period;
    logic                 ref_neg;
    logic [CNT_WIDTH:0]   period_ext, mag_raw, mag_sat, mag_eff;
    logic                 level_on;
    logic [1:0]           lev_req;

    // Strobe capture; a load in the same cycle sees the new value.
    assign ref_pend_next = ref_valid ? ref_in : ref_pend_reg;

    // Carrier counter and load/sync generation. Loads are applied on the
    // edge that enters the valley/peak, so the flagged carrier value and
    // the freshly loaded reference appear together.
    always_comb begin
        cnt_next         = cnt_reg;
        dir_up_next      = dir_up_reg;
        sync_valley_next = 1'b0;
        sync_peak_next   = 1'b0;
        load_ref         = 1'b0;
        load_period      = 1'b0;
        step_up          = dir_up_reg;
        if (!en) begin
            cnt_next    = '0;
            dir_up_next = 1'b1;
        end else if (!run_reg || period_act_reg == '0) begin
            // First enabled cycle, or idling on a zero period: sit at the
            // valley and keep reloading until a usable period arrives.
            cnt_next         = '0;
            dir_up_next      = 1'b1;
            load_ref         = 1'b1;
            load_period      = 1'b1;
            sync_valley_next = (period != '0);
        end else begin
            if (cnt_reg == '0)
                step_up = 1'b1;
            else if (cnt_reg >= period_act_reg)
                step_up = 1'b0;
            cnt_next    = step_up ? cnt_reg + 1'b1 : cnt_reg - 1'b1;
            dir_up_next = step_up;
            if (cnt_next == '0) begin
                load_ref         = 1'b1;
                load_period      = 1'b1;
                sync_valley_next = (period != '0);
            end else if (cnt_next == period_act_reg) begin
                load_ref       = 1'b1;
                sync_peak_next = 1'b1;
            end
        end
    end

    // Magnitude: |ref| in CNT_WIDTH+1 bits, saturated to the period, then
    // optionally snapped away from sub-threshold pulses and gaps.
    always_comb begin
        ref_neg    = ref_act_reg[CNT_WIDTH];
        period_ext = {1'b0, period_act_reg};
        mag_raw    = ref_neg ? (~ref_act_reg + 1'b1) : ref_act_reg;
        mag_sat    = (mag_raw > period_ext) ? period_ext : mag_raw;
        mag_eff    = mag_sat;
        if (PULSE_GUARD && mag_sat != '0) begin
            if (mag_sat < MIN_PULSE_C)
                mag_eff = '0;
            else if ((period_ext - mag_sat) < MIN_PULSE_C)
                mag_eff = period_ext;
        end
        level_on = (period_act_reg != '0) &&
                   ((mag_eff == period_ext) || ({1'b0, cnt_reg} < mag_eff));
        lev_req  = LEV_ZERO;
        if (run_reg && level_on)
            lev_req = ref_neg ? LEV_NEG : LEV_POS;
    end

    // Sign-change guard: a direct 01<->10 request parks the output at 00 for
    // MIN_ZERO cycles; the request is simply re-evaluated afterwards.
    always_comb begin
        v_lev_next = lev_req;
        hold_next  = hold_reg;
        if (!en) begin
            v_lev_next = LEV_ZERO;
            hold_next  = '0;
        end else if (hold_reg != '0) begin
            v_lev_next = LEV_ZERO;
            hold_next  = hold_reg - 8'd1;
        end else if ((v_lev_reg == LEV_POS && lev_req == LEV_NEG) ||
                     (v_lev_reg == LEV_NEG && lev_req == LEV_POS)) begin
            v_lev_next = LEV_ZERO;
            hold_next  = HOLD_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg         <= '0;
            dir_up_reg      <= 1'b1;
            run_reg         <= 1'b0;
            ref_pend_reg    <= '0;
            ref_act_reg     <= '0;
            period_act_reg  <= '0;
            sync_valley_reg <= 1'b0;
            sync_peak_reg   <= 1'b0;
            v_lev_reg       <= LEV_ZERO;
            hold_reg        <= '0;
        end else begin
            cnt_reg         <= cnt_next;
            dir_up_reg      <= dir_up_next;
            run_reg         <= en;
            ref_pend_reg    <= ref_pend_next;
            sync_valley_reg <= sync_valley_next;
            sync_peak_reg   <= sync_peak_next;
            v_lev_reg       <= v_lev_next;
            hold_reg        <= hold_next;
            if (load_ref)
                ref_act_reg <= ref_pend_next;
            if (load_period)
                period_act_reg <= period;
        end
    end

    assign v_lev       = v_lev_reg;
    assign carrier     = cnt_reg;
    assign sync_valley = sync_valley_reg;
    assign sync_peak   = sync_peak_reg;

endmodule
